// File: rtl/mux_pkg.sv
// Shared encodings for the N-channel registered selector.
package mux_pkg;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping to 0.
module rr_pick #(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] g
);
  logic [2*NCH-1:0] w_dbl;
  int               w_idx;

  assign w_dbl = {req, req};

  // Scan from the far end so the lowest offset from ptr wins.
  always_comb begin
    any   = 1'b0;
    g     = '0;
    w_idx = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_dbl[int'(ptr) + k]) begin
        any   = 1'b1;
        w_idx = int'(ptr) + k;
        if (w_idx >= NCH) w_idx = w_idx - NCH;
        g     = SELW'(w_idx);
      end
    end
  end
endmodule

// File: rtl/mux_arb_n.sv
// N-channel registered selector, direct-select or round-robin, with
// valid/ready on every channel and one cycle of latency.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_ch;
  logic             r_valid;
  logic [SELW-1:0]  r_ptr;

  logic             w_rr_any;
  logic [SELW-1:0]  w_rr_g;
  logic             w_any;
  logic [SELW-1:0]  w_g;
  logic             w_load_en;
  logic             w_xfer;

  rr_pick #(.NCH(NCH), .SELW(SELW)) u_rr_pick (
    .req (in_valid),
    .ptr (r_ptr),
    .any (w_rr_any),
    .g   (w_rr_g)
  );

  // An out-of-range sel (non power-of-two NCH) grants nothing.
  always_comb begin
    w_any = 1'b0;
    w_g   = '0;
    if (mode == MODE_RR) begin
      w_any = w_rr_any;
      w_g   = w_rr_g;
    end else if (int'(sel) < NCH) begin
      if (in_valid[sel]) begin
        w_any = 1'b1;
        w_g   = sel;
      end
    end
  end

  assign w_load_en = ~r_valid | out_ready;
  assign w_xfer    = w_any & w_load_en;

  always_comb begin
    in_ready = '0;
    if (w_xfer) in_ready[w_g] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else begin
      if (w_xfer) begin
        r_data  <= in_data[int'(w_g)*WIDTH +: WIDTH];
        r_ch    <= w_g;
        r_valid <= 1'b1;
        if (mode == MODE_RR)
          r_ptr <= (w_g == SELW'(NCH - 1)) ? '0 : w_g + 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: a 4-channel instance for the main function
// and a 3-channel instance for the out-of-range select case.
module tb_mux_arb_n;
  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        mode4, out_ready4;
  logic [1:0]  sel4;
  logic [63:0] in_data4;
  logic [3:0]  in_valid4, in_ready4;
  logic [15:0] out_data4;
  logic [1:0]  out_ch4;
  logic        out_valid4;

  logic        mode3, out_ready3;
  logic [1:0]  sel3;
  logic [47:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [15:0] out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(16), .NCH(4)) u4 (
    .clk(clk), .rst(rst), .mode(mode4), .sel(sel4), .in_data(in_data4),
    .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
    .out_ch(out_ch4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  mux_arb_n #(.WIDTH(16), .NCH(3)) u3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mode4 = 1'b1; sel4 = 2'd0; out_ready4 = 1'b1; in_valid4 = 4'b1111;
    in_data4 = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1; in_valid3 = 3'b000;
    in_data3 = {16'hC002, 16'hC001, 16'hC000};

    // Reset with all inputs active.
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_out_data",  32'(out_data4),  32'd0);
    chk("rst_out_ch",    32'(out_ch4),    32'd0);
    chk("rst_in_ready",  32'(in_ready4),  32'b0001);
    tick();
    chk("rst_hold_valid", 32'(out_valid4), 32'd0);
    #3 rst = 1'b0;
    #1;
    chk("first_rr_ready", 32'(in_ready4), 32'b0001);

    // Fairness: all valid, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_ch%0d", i),    32'(out_ch4),    32'(i % 4));
      chk($sformatf("rr_data%0d", i),  32'(out_data4),  32'(16'hA000 + (i % 4)));
      chk($sformatf("rr_valid%0d", i), 32'(out_valid4), 32'd1);
    end
    chk("rr_ptr_wrap", 32'(u4.r_ptr), 32'd0);

    // Direct select of channel 2.
    mode4 = 1'b0; sel4 = 2'd2; in_data4[2*16 +: 16] = 16'hBEEF;
    #1;
    chk("dir_in_ready", 32'(in_ready4), 32'b0100);
    tick();
    chk("dir_out_data", 32'(out_data4), 32'hBEEF);
    chk("dir_out_ch",   32'(out_ch4),   32'd2);
    chk("dir_ptr",      32'(u4.r_ptr),  32'd0);

    // Move ptr to 1, then skip over idle channels 1 and 2.
    mode4 = 1'b1; in_valid4 = 4'b0001;
    tick();
    chk("skip_setup_ptr", 32'(u4.r_ptr), 32'd1);
    in_valid4 = 4'b1001;
    #1;
    chk("skip_ready3", 32'(in_ready4), 32'b1000);
    tick();
    chk("skip_ch3",  32'(out_ch4),  32'd3);
    chk("skip_ptr0", 32'(u4.r_ptr), 32'd0);
    #1;
    chk("skip_ready0", 32'(in_ready4), 32'b0001);
    tick();
    chk("skip_ch0",  32'(out_ch4),  32'd0);
    chk("skip_ptr1", 32'(u4.r_ptr), 32'd1);

    // Backpressure: load 0x1234, then stall with other channels valid.
    mode4 = 1'b0; sel4 = 2'd1; in_valid4 = 4'b1111; in_data4[1*16 +: 16] = 16'h1234;
    tick();
    chk("bp_load", 32'(out_data4), 32'h1234);
    out_ready4 = 1'b0; sel4 = 2'd3; in_data4[3*16 +: 16] = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready%0d", i), 32'(in_ready4), 32'd0);
      tick();
      chk($sformatf("bp_data%0d", i),  32'(out_data4),  32'h1234);
      chk($sformatf("bp_valid%0d", i), 32'(out_valid4), 32'd1);
      chk($sformatf("bp_ch%0d", i),    32'(out_ch4),    32'd1);
    end
    out_ready4 = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready4), 32'b1000);
    tick();
    chk("bp_reload_valid", 32'(out_valid4), 32'd1);
    chk("bp_reload_data",  32'(out_data4),  32'h5678);
    chk("bp_reload_ch",    32'(out_ch4),    32'd3);

    // Drain with nothing offered: valid drops, data and channel hold.
    in_valid4 = 4'b0000;
    tick();
    chk("drain_valid", 32'(out_valid4), 32'd0);
    chk("drain_data",  32'(out_data4),  32'h5678);
    chk("drain_ch",    32'(out_ch4),    32'd3);

    // Out-of-range select on the 3-channel instance.
    sel3 = 2'd3; in_valid3 = 3'b111;
    #1;
    chk("oor_ready", 32'(in_ready3), 32'd0);
    tick();
    chk("oor_valid", 32'(out_valid3), 32'd0);
    sel3 = 2'd2;
    #1;
    chk("n3_ready2", 32'(in_ready3), 32'b100);
    tick();
    chk("n3_valid", 32'(out_valid3), 32'd1);
    chk("n3_data",  32'(out_data3),  32'hC002);
    chk("n3_ch",    32'(out_ch3),    32'd2);

    // Mid-stream asynchronous reset with both outputs holding data.
    out_ready3 = 1'b0;
    mode4 = 1'b1; in_valid4 = 4'b0100; out_ready4 = 1'b0;
    tick();
    chk("mid_pre_valid4", 32'(out_valid4), 32'd1);
    chk("mid_pre_ptr4",   32'(u4.r_ptr),   32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid3", 32'(out_valid3), 32'd0);
    chk("mid_rst_valid4", 32'(out_valid4), 32'd0);
    chk("mid_rst_data4",  32'(out_data4),  32'd0);
    chk("mid_rst_ptr4",   32'(u4.r_ptr),   32'd0);
    #1 rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
